// File: rtl/reg_wb_pkg.sv
// Shared constants and the queued write-back entry type for the register write-back queue.
package reg_wb_pkg;

  localparam int unsigned N     = 5;
  localparam int unsigned M     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;

  typedef struct packed {
    logic [N-1:0] addr;
    logic [M-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_queue_if.sv
// Producer requests, register-file write port and forwarding lookup of the write-back queue.
interface reg_wb_queue_if #(
  parameter int unsigned N     = reg_wb_pkg::N,
  parameter int unsigned M     = reg_wb_pkg::M,
  parameter int unsigned DEPTH = reg_wb_pkg::DEPTH
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          mem_valid;
  logic [N-1:0]  mem_addr;
  logic [M-1:0]  mem_data;
  logic          mem_ready;
  logic          alu_valid;
  logic [N-1:0]  alu_addr;
  logic [M-1:0]  alu_data;
  logic          alu_ready;
  logic [N-1:0]  a3;
  logic [M-1:0]  wd;
  logic          we;
  logic [N-1:0]  ra1;
  logic [N-1:0]  ra2;
  logic          fwd_hit1;
  logic [M-1:0]  fwd_data1;
  logic          fwd_hit2;
  logic [M-1:0]  fwd_data2;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport master (
    output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, ra1, ra2,
    input  mem_ready, alu_ready, a3, wd, we, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
           count, full, empty
  );

  modport slave (
    input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, ra1, ra2,
    output mem_ready, alu_ready, a3, wd, we, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
           count, full, empty
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order entry storage with two ordered push ports and one pop; exposes contents oldest-first.
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH = reg_wb_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push0,
  input  wb_entry_t                entry0,
  input  logic                     push1,
  input  wb_entry_t                entry1,
  input  logic                     pop,
  output wb_entry_t                ordered [DEPTH],
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned FPW = $clog2(DEPTH);
  localparam int unsigned FCW = FPW + 1;

  wb_entry_t          slots [DEPTH];
  logic [FPW-1:0]     wr_ptr;
  logic [FPW-1:0]     rd_ptr;
  logic [FPW-1:0]     wr_ptr1;

  // push1 lands behind push0 when both fire
  assign wr_ptr1 = wr_ptr + FPW'(push0);

  // storage is never reset; validity comes from count alone
  always_ff @(posedge clk) begin
    if (push0) slots[wr_ptr]  <= entry0;
    if (push1) slots[wr_ptr1] <= entry1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + FPW'(push0) + FPW'(push1);
      rd_ptr <= rd_ptr + FPW'(pop);
      count  <= count + FCW'(push0) + FCW'(push1) - FCW'(pop);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ordered[i] = slots[rd_ptr + FPW'(i)];
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// Register write-back queue: arbitrates load/ALU results, drops x0 writes, drains one entry
// per cycle into the register file and forwards pending values to the read ports.
module reg_wb_queue
  import reg_wb_pkg::*;
#(
  parameter int unsigned N     = reg_wb_pkg::N,
  parameter int unsigned M     = reg_wb_pkg::M,
  parameter int unsigned DEPTH = reg_wb_pkg::DEPTH
) (
  input logic           clk,
  input logic           rst_n,
  reg_wb_queue_if.slave bus
);

  localparam int unsigned QCW = $clog2(DEPTH) + 1;

  wb_entry_t       ordered [DEPTH];
  logic [QCW-1:0]  count;
  logic [QCW-1:0]  free;
  logic            empty;
  logic            pop;
  logic            mem_nz, alu_nz;
  logic            mem_ready, alu_ready;
  logic            mem_push, alu_push;
  logic [N-1:0]    head_addr;
  logic [M-1:0]    head_data;
  wb_entry_t       mem_entry, alu_entry;

  assign empty     = (count == '0);
  assign pop       = !empty;
  assign free      = QCW'(DEPTH) - count + QCW'(pop);
  assign mem_nz    = (bus.mem_addr != '0);
  assign alu_nz    = (bus.alu_addr != '0);

  // load wins the last free slot; x0 requests are always taken and dropped
  assign mem_ready = (free >= QCW'(1)) || !mem_nz;
  assign alu_ready = !alu_nz || (free >= QCW'(2)) ||
                     ((free >= QCW'(1)) && !(bus.mem_valid && mem_nz));
  assign mem_push  = bus.mem_valid && mem_ready && mem_nz;
  assign alu_push  = bus.alu_valid && alu_ready && alu_nz;

  assign mem_entry = '{addr: bus.mem_addr, data: bus.mem_data};
  assign alu_entry = '{addr: bus.alu_addr, data: bus.alu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push0   (mem_push),
    .entry0  (mem_entry),
    .push1   (alu_push),
    .entry1  (alu_entry),
    .pop     (pop),
    .ordered (ordered),
    .count   (count)
  );

  assign head_addr = empty ? '0 : ordered[0].addr;
  assign head_data = empty ? '0 : ordered[0].data;

  always_comb begin
    bus.mem_ready = mem_ready;
    bus.alu_ready = alu_ready;
    bus.we        = pop;
    bus.a3        = head_addr;
    bus.wd        = head_data;
    bus.count     = count;
    bus.full      = (count == QCW'(DEPTH));
    bus.empty     = empty;
  end

  // scan oldest to youngest so the last match is the youngest pending write
  always_comb begin
    bus.fwd_hit1  = 1'b0;
    bus.fwd_data1 = '0;
    bus.fwd_hit2  = 1'b0;
    bus.fwd_data2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (QCW'(i) < count) begin
        if ((bus.ra1 != '0) && (ordered[i].addr == bus.ra1)) begin
          bus.fwd_hit1  = 1'b1;
          bus.fwd_data1 = ordered[i].data;
        end
        if ((bus.ra2 != '0) && (ordered[i].addr == bus.ra2)) begin
          bus.fwd_hit2  = 1'b1;
          bus.fwd_data2 = ordered[i].data;
        end
      end
    end
  end

endmodule
